// File: rtl/turn_controller.sv
// rtl/turn_controller.sv - turn sequencing FSM for the Chicken Cha-Cha-Cha datapath
module turn_controller #(
  parameter int REVEAL_CYCLES = 50_000_000,
  parameter int CW            = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] num_players,
  input  logic       select,
  input  logic [3:0] card_sel,
  input  logic       go,
  input  logic       W,
  output logic [1:0] N,
  output logic [3:0] position_data,
  output logic       A,
  output logic       B,
  output logic       statecombo_next_turn,
  output logic       reveal,
  output logic       game_over
);

  typedef enum logic [3:0] {
    IDLE,
    WAIT_SEL,
    CHECK,
    EVAL,
    MOVE,
    WIN_CHK,
    REVEAL,
    NEXT,
    OVER
  } state_t;

  localparam logic [CW-1:0] RELOAD = CW'(REVEAL_CYCLES - 1);

  state_t        state_q, state_d;
  logic [1:0]    n_q, n_d;
  logic [3:0]    pos_q, pos_d;
  logic [11:0]   used_q, used_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic game_start;
  logic sel_ok;

  assign game_start = start && (num_players != 2'd0);
  assign sel_ok     = select && (card_sel <= 4'd11) && !used_q[card_sel];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      n_q     <= 2'd0;
      pos_q   <= 4'd0;
      used_q  <= 12'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      pos_q   <= pos_d;
      used_q  <= used_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    pos_d   = pos_q;
    used_d  = used_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE, OVER: begin
        // select is never honoured here; only a legal start leaves
        if (game_start) begin
          n_d     = num_players;
          used_d  = 12'd0;
          state_d = WAIT_SEL;
        end
      end
      WAIT_SEL: begin
        if (sel_ok) begin
          pos_d   = card_sel;
          state_d = CHECK;
        end
      end
      CHECK: state_d = EVAL;
      EVAL: begin
        if (go) begin
          used_d[pos_q] = 1'b1;
          state_d       = MOVE;
        end else begin
          cnt_d   = RELOAD;
          state_d = REVEAL;
        end
      end
      MOVE: state_d = WIN_CHK;
      WIN_CHK: state_d = W ? OVER : WAIT_SEL;
      REVEAL: begin
        if (cnt_q == '0) begin
          state_d = NEXT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      NEXT: begin
        used_d  = 12'd0;
        state_d = WAIT_SEL;
      end
      default: state_d = IDLE;
    endcase
  end

  // all strobes are pure state decodes, so reset kills them on the next edge
  assign N                    = n_q;
  assign position_data        = pos_q;
  assign A                    = (state_q == CHECK);
  assign B                    = (state_q == MOVE);
  assign statecombo_next_turn = (state_q == NEXT);
  assign reveal               = (state_q == REVEAL);
  assign game_over            = (state_q == OVER);

endmodule

// File: doc/turn_controller.md
# turn_controller

Upstream control stage for the Chicken Cha-Cha-Cha game datapath. Latches the player count, accepts tile selections from the board input logic, strobes the tile-match check (`A`) and the move/win check (`B`), waits for the `go` and `W` results, runs a timed reveal on a miss, and pulses `statecombo_next_turn` to hand the turn to the next player. Ends the game on a win and holds until restarted.

## Interface

Parameters:
- `REVEAL_CYCLES`, default 50_000_000: cycles the mismatched tile stays revealed. 1 s at 50 MHz. Must be ≥ 1.
- `CW`, default 26: width of the reveal counter. Must satisfy 2^CW > REVEAL_CYCLES.

Ports:
- `clk` in 1: single system clock; all logic is rising-edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse that begins a game.
- `num_players` in 2: player count minus 1; legal values 1..3 (2–4 players).
- `select` in 1: one-cycle pulse when the current player picks a tile.
- `card_sel` in 4: tile index of the pick; legal 0..11.
- `go` in 1: tile-match result. Valid exactly 1 cycle after `A`.
- `W` in 1: win result. Valid exactly 1 cycle after `B`.
- `N` out 2: latched player count to the datapath.
- `position_data` out 4: registered tile index under test.
- `A` out 1: one-cycle match-check strobe.
- `B` out 1: one-cycle move/win-check strobe.
- `statecombo_next_turn` out 1: one-cycle turn-advance pulse.
- `reveal` out 1: high while a missed tile is shown.
- `game_over` out 1: high from the win until restart.

## Operation

States: IDLE, WAIT_SEL, CHECK, EVAL, MOVE, WIN_CHK, REVEAL, NEXT, OVER.

- **IDLE**
  - On `start` with `num_players` ≠ 0: latch `N`, clear `used`, go to WAIT_SEL.
  - On `start` with `num_players` = 0: ignore it and stay in IDLE.
- **WAIT_SEL**
  - On `select` with `card_sel` ≤ 11 and `used[card_sel]` = 0: register `position_data` ← `card_sel`, go to CHECK.
  - On any other `select`: ignore it and stay.
- **CHECK**: `A` = 1 for this cycle only. Go to EVAL.
- **EVAL**: sample `go`.
  - `go` = 1: set `used[position_data]`, go to MOVE.
  - `go` = 0: load the counter with REVEAL_CYCLES−1, go to REVEAL.
- **MOVE**: `B` = 1 for this cycle only. Go to WIN_CHK.
- **WIN_CHK**: sample `W`.
  - `W` = 1: go to OVER.
  - `W` = 0: go to WAIT_SEL. The same player continues.
- **REVEAL**: `reveal` = 1. Decrement the counter; when it is 0, go to NEXT.
- **NEXT**: `statecombo_next_turn` = 1 for one cycle, clear `used`, go to WAIT_SEL.
- **OVER**: `game_over` = 1.
  - `start` with `num_players` ≠ 0 relatches `N`, clears `used`, and goes to WAIT_SEL.
  - `select` is ignored.

Other rules:
- `used` is a 12-bit mask of tiles matched in the current turn. It is cleared at turn end and at game start.
- `start` is ignored in every state except IDLE and OVER.
- `position_data` and `N` hold their values outside the load events above.
- If `select` and `start` occur in the same cycle: `start` has priority in IDLE/OVER; `select` has priority in WAIT_SEL.

## Timing

- Reset values: state IDLE, `N`=0, `position_data`=0, `A`=`B`=`statecombo_next_turn`=`reveal`=`game_over`=0, `used`=0, counter=0.
- `reset` mid-operation returns to IDLE at the next edge. Any strobe or reveal in progress is aborted and no pulse completes.
- All outputs are registered or decoded from the state register; no combinational path from input to output.
- Select → `A`: `select` sampled at edge k gives `A` high during cycle k+1. `position_data` is already stable in that cycle.
- `go` sampled at edge k+2; on a hit, `B` is high during cycle k+3; `W` sampled at edge k+4.
- A hit without a win returns to WAIT_SEL at edge k+4.
- On a miss, `reveal` is high for exactly REVEAL_CYCLES cycles. `statecombo_next_turn` follows in the next cycle. WAIT_SEL is re-entered one cycle after that.
- `select` pulses arriving outside WAIT_SEL are dropped, not queued.

## Test plan

- Reset/start:
  - Reset, then `start` with `num_players`=0 → stays IDLE, `N`=0.
  - `start` with `num_players`=3 → `N`=3 next cycle, WAIT_SEL.
- Hit path (REVEAL_CYCLES=4):
  - `select`, `card_sel`=5, `go`=1, `W`=0 → `A` one cycle after `select`; `B` 2 cycles after `A`.
  - No `statecombo_next_turn`; `used[5]`=1.
  - A second `select` of 5 is ignored.
- Miss path (REVEAL_CYCLES=4):
  - `select` 7, `go`=0 → `reveal` high for exactly 4 cycles, then one `statecombo_next_turn` pulse.
  - `used` cleared; `select` 5 is then accepted again.
- Win:
  - `go`=1, `W`=1 → `game_over`=1 and held.
  - A later `select` produces no `A`.
  - `start` with `num_players`=2 → `game_over`=0, `N`=2.
- Illegal and ignored input:
  - `card_sel`=12..15 with `select` → no `A`.
  - `start` during REVEAL → ignored; reveal count unchanged.
- Reset mid-operation:
  - Assert `reset` during cycle 2 of REVEAL → next cycle all outputs 0, IDLE.
  - No `statecombo_next_turn` pulse is ever emitted.
